// File: rtl/dm_bus_bridge_pkg.sv
// Shared types and defaults for the data-memory bus bridge.
package dm_bus_bridge_pkg;

  // FSM encodings (2-bit)
  typedef enum logic [1:0] {
    DBB_ST_IDLE     = 2'd0,
    DBB_ST_BUS_REQ  = 2'd1,
    DBB_ST_BUS_WAIT = 2'd2,
    DBB_ST_RESP     = 2'd3
  } dbb_state_e;

  // Memory-map defaults for the decoded data window
  localparam logic [63:0] DBB_ADDR_BASE      = 64'h0000_0000_8000_0000;
  localparam logic [63:0] DBB_ADDR_SIZE      = 64'h0000_0000_1000_0000;
  localparam int          DBB_TIMEOUT_CYCLES = 256;

  // Unsigned offset compare: addresses below the base wrap to huge offsets
  // and therefore fall outside the window.
  function automatic logic dbb_in_window(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] size);
    return (addr - base) < size;
  endfunction

  // Doubleword-aligned bus address
  function automatic logic [63:0] dbb_align(input logic [63:0] addr);
    return {addr[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/dm_bus_bridge.sv
// Data-memory bridge: one outstanding load/store from the LSP, issued as a
// 64-bit aligned transaction on the external data bus, with window decode
// and bus timeout both completing as an error response.
module dm_bus_bridge
  import dm_bus_bridge_pkg::*;
#(
  parameter logic [63:0] ADDR_BASE      = DBB_ADDR_BASE,
  parameter logic [63:0] ADDR_SIZE      = DBB_ADDR_SIZE,
  parameter int          TIMEOUT_CYCLES = DBB_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] dm_req_addr,
  input  logic [63:0] dm_req_wdata,
  input  logic [7:0]  dm_req_wmask,
  input  logic        dm_req_wen,
  input  logic        dm_req_valid,
  output logic        dm_req_ready,
  output logic [63:0] dm_resp_rdata,
  output logic        dm_resp_valid,
  output logic        dm_resp_err,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wmask,
  output logic        bus_wen,
  output logic        bus_valid,
  input  logic        bus_ready,
  input  logic [63:0] bus_rdata,
  input  logic        bus_rvalid,
  output logic        dm_busy
);

  // Counter must be able to hold TIMEOUT_CYCLES itself: when a bus event wins
  // on the last cycle, the count steps one past the limit in BUS_WAIT.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic TO_EN = (TIMEOUT_CYCLES > 0);

  dbb_state_e       r_state;
  dbb_state_e       w_next_state;
  logic [CNT_W-1:0] r_cnt;

  logic        w_accept;
  logic        w_in_win;
  logic        w_timeout;
  logic        w_bus_ok;

  logic        w_resp_valid_d;
  logic        w_resp_err_d;
  logic [63:0] w_resp_rdata_d;
  logic        w_bus_valid_d;

  logic [63:0] r_resp_rdata;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [63:0] r_bus_addr;
  logic [63:0] r_bus_wdata;
  logic [7:0]  r_bus_wmask;
  logic        r_bus_wen;
  logic        r_bus_valid;

  assign dm_req_ready = (r_state == DBB_ST_IDLE);
  assign dm_busy      = (r_state != DBB_ST_IDLE);

  assign w_accept  = dm_req_valid && (r_state == DBB_ST_IDLE);
  assign w_in_win  = dbb_in_window(dm_req_addr, ADDR_BASE, ADDR_SIZE);
  assign w_timeout = TO_EN && (r_cnt >= TO_LAST);
  assign w_bus_ok  = (r_state == DBB_ST_BUS_WAIT) && bus_rvalid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= DBB_ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; a bus event takes priority over an expiring timeout
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      DBB_ST_IDLE: begin
        if (w_accept) w_next_state = w_in_win ? DBB_ST_BUS_REQ : DBB_ST_RESP;
      end
      DBB_ST_BUS_REQ: begin
        if (bus_ready)      w_next_state = DBB_ST_BUS_WAIT;
        else if (w_timeout) w_next_state = DBB_ST_RESP;
      end
      DBB_ST_BUS_WAIT: begin
        if (bus_rvalid)     w_next_state = DBB_ST_RESP;
        else if (w_timeout) w_next_state = DBB_ST_RESP;
      end
      DBB_ST_RESP: w_next_state = DBB_ST_IDLE;
      default:     w_next_state = DBB_ST_IDLE;
    endcase
  end

  // Next values for the registered outputs, derived from the transition taken
  always_comb begin
    w_bus_valid_d  = (w_next_state == DBB_ST_BUS_REQ);
    w_resp_valid_d = (w_next_state == DBB_ST_RESP);
    w_resp_err_d   = (w_next_state == DBB_ST_RESP) && !w_bus_ok;
    w_resp_rdata_d = (w_bus_ok && !r_bus_wen) ? bus_rdata : 64'd0;
  end

  // Output/datapath registers and timeout counter; everything is cleared on
  // reset so an aborted transaction leaves nothing visible on the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_rdata <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_bus_wmask  <= '0;
      r_bus_wen    <= 1'b0;
      r_bus_valid  <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_resp_rdata <= w_resp_rdata_d;
      r_resp_valid <= w_resp_valid_d;
      r_resp_err   <= w_resp_err_d;
      r_bus_valid  <= w_bus_valid_d;
      if (w_accept && w_in_win) begin
        r_bus_addr  <= dbb_align(dm_req_addr);
        r_bus_wdata <= dm_req_wdata;
        r_bus_wmask <= dm_req_wen ? dm_req_wmask : 8'h00;
        r_bus_wen   <= dm_req_wen;
      end
      if (w_accept) begin
        r_cnt <= '0;
      end else if (TO_EN && (r_state == DBB_ST_BUS_REQ || r_state == DBB_ST_BUS_WAIT)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign dm_resp_rdata = r_resp_rdata;
  assign dm_resp_valid = r_resp_valid;
  assign dm_resp_err   = r_resp_err;
  assign bus_addr      = r_bus_addr;
  assign bus_wdata     = r_bus_wdata;
  assign bus_wmask     = r_bus_wmask;
  assign bus_wen       = r_bus_wen;
  assign bus_valid     = r_bus_valid;

endmodule
